// File: rtl/ddr_datapath_write.sv
// DDR write datapath: buffers system write words/masks and serialises them into
// registered rise/fall byte pairs with DQ/DQS enables, preamble and postamble.
module ddr_datapath_write #(
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int WL         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sys_data_w,
  input  logic [1:0]  sys_mask_w,
  input  logic        sys_wvalid,
  output logic        sys_wready,
  input  logic        wr_start,
  output logic [7:0]  dq_rise,
  output logic [7:0]  dq_fall,
  output logic        dm_rise,
  output logic        dm_fall,
  output logic        dq_oe,
  output logic        dqs_oe,
  output logic        dqs_rise,
  output logic        wr_busy,
  output logic        wr_underrun,
  output logic [3:0]  fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [2:0] LAT_LAST = (WL > 1) ? 3'(WL - 2) : 3'd0;
  localparam logic [2:0] BEAT_LAST = 3'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, LATENCY, PREAMBLE, BURST, POSTAMBLE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, pop;
  logic [17:0]   rd_word;

  logic [7:0] dq_rise_q, dq_rise_d, dq_fall_q, dq_fall_d;
  logic       dm_rise_q, dm_rise_d, dm_fall_q, dm_fall_d;
  logic       dq_oe_q, dq_oe_d, dqs_oe_q, dqs_oe_d, dqs_rise_q, dqs_rise_d;
  logic       busy_q, busy_d, underrun_q, underrun_d;

  // Write handshake: a word is taken on any edge where sys_wvalid && sys_wready;
  // sys_wready depends only on FIFO fullness and rst, never on sys_wvalid.
  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign sys_wready = !full && !rst;
  assign push       = sys_wvalid && sys_wready;
  assign pop        = (state_q == BURST) && !empty;
  assign rd_word    = mem_q[rptr_q];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dq_rise_d  = '0;
    dq_fall_d  = '0;
    dm_rise_d  = 1'b0;
    dm_fall_d  = 1'b0;
    dq_oe_d    = 1'b0;
    dqs_oe_d   = 1'b0;
    dqs_rise_d = 1'b0;
    busy_d     = (state_q != IDLE);
    underrun_d = underrun_q;
    case (state_q)
      IDLE: begin
        if (wr_start) begin
          underrun_d = 1'b0;
          cnt_d      = '0;
          state_d    = (WL > 1) ? LATENCY : PREAMBLE;
        end
      end
      LATENCY: begin
        if (cnt_q == LAT_LAST) state_d = PREAMBLE;
        else                   cnt_d   = cnt_q + 3'd1;
      end
      PREAMBLE: begin
        dqs_oe_d = 1'b1;
        cnt_d    = '0;
        state_d  = BURST;
      end
      BURST: begin
        dq_oe_d    = 1'b1;
        dqs_oe_d   = 1'b1;
        dqs_rise_d = 1'b1;
        // An empty FIFO at a beat drives a fully masked zero beat.
        if (empty) begin
          dm_rise_d  = 1'b1;
          dm_fall_d  = 1'b1;
          underrun_d = 1'b1;
        end else begin
          {dm_rise_d, dm_fall_d, dq_rise_d, dq_fall_d} = rd_word;
        end
        if (cnt_q == BEAT_LAST) state_d = POSTAMBLE;
        else                    cnt_d   = cnt_q + 3'd1;
      end
      POSTAMBLE: begin
        dqs_oe_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      dq_rise_q  <= '0;
      dq_fall_q  <= '0;
      dm_rise_q  <= 1'b0;
      dm_fall_q  <= 1'b0;
      dq_oe_q    <= 1'b0;
      dqs_oe_q   <= 1'b0;
      dqs_rise_q <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dq_rise_q  <= dq_rise_d;
      dq_fall_q  <= dq_fall_d;
      dm_rise_q  <= dm_rise_d;
      dm_fall_q  <= dm_fall_d;
      dq_oe_q    <= dq_oe_d;
      dqs_oe_q   <= dqs_oe_d;
      dqs_rise_q <= dqs_rise_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {sys_mask_w, sys_data_w};
  end

  assign dq_rise     = dq_rise_q;
  assign dq_fall     = dq_fall_q;
  assign dm_rise     = dm_rise_q;
  assign dm_fall     = dm_fall_q;
  assign dq_oe       = dq_oe_q;
  assign dqs_oe      = dqs_oe_q;
  assign dqs_rise    = dqs_rise_q;
  assign wr_busy     = busy_q;
  assign wr_underrun = underrun_q;
  assign fifo_level  = 4'(count_q);

endmodule

// File: tb/tb_ddr_datapath_write.sv
// Bench for ddr_datapath_write: vector table, directed corner sequences and
// random traffic checked every cycle against an edge-numbered burst model.
module tb_ddr_datapath_write;
  localparam int BL = 4;
  localparam int DEPTH = 8;
  localparam int WL = 2;

  logic        clk = 1'b0;
  logic        rst, sys_wvalid, sys_wready, wr_start;
  logic [15:0] sys_data_w;
  logic [1:0]  sys_mask_w;
  logic [7:0]  dq_rise, dq_fall;
  logic        dm_rise, dm_fall, dq_oe, dqs_oe, dqs_rise, wr_busy, wr_underrun;
  logic [3:0]  fifo_level;

  always #5 clk = ~clk;

  ddr_datapath_write #(.BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .WL(WL)) dut (
    .clk(clk), .rst(rst), .sys_data_w(sys_data_w), .sys_mask_w(sys_mask_w),
    .sys_wvalid(sys_wvalid), .sys_wready(sys_wready), .wr_start(wr_start),
    .dq_rise(dq_rise), .dq_fall(dq_fall), .dm_rise(dm_rise), .dm_fall(dm_fall),
    .dq_oe(dq_oe), .dqs_oe(dqs_oe), .dqs_rise(dqs_rise), .wr_busy(wr_busy),
    .wr_underrun(wr_underrun), .fifo_level(fifo_level)
  );

  typedef struct packed {
    logic [7:0] dq_rise;
    logic [7:0] dq_fall;
    logic       dm_rise;
    logic       dm_fall;
    logic       dq_oe;
    logic       dqs_oe;
    logic       dqs_rise;
    logic       wr_busy;
    logic       wr_underrun;
    logic       sys_wready;
    logic [3:0] fifo_level;
  } outs_t;

  typedef struct {
    logic        r;
    logic        w;
    logic [15:0] d;
    logic [1:0]  m;
    logic        s;
    outs_t       e;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int e_n     = 0;

  // Reference model: FIFO contents as a queue, burst phase from edge arithmetic.
  logic [17:0] exp_q[$];
  int          k_edge = 0;
  bit          act = 0;
  bit          ur = 0;
  outs_t       exp_o;

  function automatic outs_t mk(logic [7:0] r, logic [7:0] f, logic [1:0] dm, logic [2:0] oe,
                               logic busy, logic urun, logic wrdy, logic [3:0] lvl);
    return {r, f, dm, oe, busy, urun, wrdy, lvl};
  endfunction

  function automatic vec_t v(logic r, logic w, logic [15:0] d, logic [1:0] m, logic s, outs_t e);
    vec_t x;
    x.r = r; x.w = w; x.d = d; x.m = m; x.s = s; x.e = e;
    return x;
  endfunction

  function automatic outs_t get_outs();
    return {dq_rise, dq_fall, dm_rise, dm_fall, dq_oe, dqs_oe, dqs_rise,
            wr_busy, wr_underrun, sys_wready, fifo_level};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %h want %h", name, e_n, got, want);
    end
  endtask

  task automatic model_edge(input logic r, input logic w, input logic [15:0] d,
                            input logic [1:0] m, input logic s);
    bit          act_pre;
    bit          ready_pre;
    int          rel;
    logic [17:0] x;
    exp_o = '0;
    if (r) begin
      exp_q.delete();
      act = 0;
      ur  = 0;
    end else begin
      act_pre   = act;
      ready_pre = (exp_q.size() < DEPTH);
      rel       = e_n - k_edge;
      exp_o.wr_busy = act_pre;
      if (act_pre) begin
        if (rel == WL || rel == WL + BL + 1) exp_o.dqs_oe = 1'b1;
        if (rel > WL && rel <= WL + BL) begin
          exp_o.dq_oe = 1'b1; exp_o.dqs_oe = 1'b1; exp_o.dqs_rise = 1'b1;
          if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            exp_o.dm_rise = x[17]; exp_o.dm_fall = x[16];
            exp_o.dq_rise = x[15:8]; exp_o.dq_fall = x[7:0];
          end else begin
            exp_o.dm_rise = 1'b1; exp_o.dm_fall = 1'b1;
            ur = 1;
          end
        end
        if (rel == WL + BL + 1) act = 0;
      end
      if (w && ready_pre) exp_q.push_back({m, d});
      if (!act_pre && s) begin
        k_edge = e_n;
        act    = 1;
        ur     = 0;
      end
    end
    exp_o.wr_underrun = ur;
    exp_o.fifo_level  = 4'(exp_q.size());
    exp_o.sys_wready  = !r && (exp_q.size() < DEPTH);
  endtask

  task automatic step(input logic r, input logic w, input logic [15:0] d,
                      input logic [1:0] m, input logic s);
    rst = r; sys_wvalid = w; sys_data_w = d; sys_mask_w = m; wr_start = s;
    @(posedge clk);
    e_n++;
    model_edge(r, w, d, m, s);
    #1;
    check("model", 32'(get_outs()), 32'(exp_o));
  endtask

  initial begin
    vec_t tbl[$];
    int   beats;
    int   pre_post;

    rst = 1'b1; sys_wvalid = 1'b0; sys_data_w = '0; sys_mask_w = '0; wr_start = 1'b0;

    // Basic burst from reset
    tbl.push_back(v(1, 0, 16'h0000, 2'b00, 0, mk(8'h00, 8'h00, 2'b00, 3'b000, 0, 0, 0, 4'd0)));
    tbl.push_back(v(0, 1, 16'hA1B2, 2'b00, 0, mk(8'h00, 8'h00, 2'b00, 3'b000, 0, 0, 1, 4'd1)));
    tbl.push_back(v(0, 1, 16'hC3D4, 2'b00, 0, mk(8'h00, 8'h00, 2'b00, 3'b000, 0, 0, 1, 4'd2)));
    tbl.push_back(v(0, 1, 16'hE5F6, 2'b00, 0, mk(8'h00, 8'h00, 2'b00, 3'b000, 0, 0, 1, 4'd3)));
    tbl.push_back(v(0, 1, 16'h0718, 2'b00, 0, mk(8'h00, 8'h00, 2'b00, 3'b000, 0, 0, 1, 4'd4)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 1, mk(8'h00, 8'h00, 2'b00, 3'b000, 0, 0, 1, 4'd4)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'h00, 8'h00, 2'b00, 3'b000, 1, 0, 1, 4'd4)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'h00, 8'h00, 2'b00, 3'b010, 1, 0, 1, 4'd4)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'hA1, 8'hB2, 2'b00, 3'b111, 1, 0, 1, 4'd3)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'hC3, 8'hD4, 2'b00, 3'b111, 1, 0, 1, 4'd2)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'hE5, 8'hF6, 2'b00, 3'b111, 1, 0, 1, 4'd1)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'h07, 8'h18, 2'b00, 3'b111, 1, 0, 1, 4'd0)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'h00, 8'h00, 2'b00, 3'b010, 1, 0, 1, 4'd0)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'h00, 8'h00, 2'b00, 3'b000, 0, 0, 1, 4'd0)));
    // Masked rise byte, then two underrun beats; underrun clears on next start
    tbl.push_back(v(0, 1, 16'h55AA, 2'b10, 0, mk(8'h00, 8'h00, 2'b00, 3'b000, 0, 0, 1, 4'd1)));
    tbl.push_back(v(0, 1, 16'h1234, 2'b00, 0, mk(8'h00, 8'h00, 2'b00, 3'b000, 0, 0, 1, 4'd2)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 1, mk(8'h00, 8'h00, 2'b00, 3'b000, 0, 0, 1, 4'd2)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'h00, 8'h00, 2'b00, 3'b000, 1, 0, 1, 4'd2)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'h00, 8'h00, 2'b00, 3'b010, 1, 0, 1, 4'd2)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'h55, 8'hAA, 2'b10, 3'b111, 1, 0, 1, 4'd1)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'h12, 8'h34, 2'b00, 3'b111, 1, 0, 1, 4'd0)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'h00, 8'h00, 2'b11, 3'b111, 1, 1, 1, 4'd0)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'h00, 8'h00, 2'b11, 3'b111, 1, 1, 1, 4'd0)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'h00, 8'h00, 2'b00, 3'b010, 1, 1, 1, 4'd0)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 0, mk(8'h00, 8'h00, 2'b00, 3'b000, 0, 1, 1, 4'd0)));
    tbl.push_back(v(0, 0, 16'h0000, 2'b00, 1, mk(8'h00, 8'h00, 2'b00, 3'b000, 0, 0, 1, 4'd0)));
    tbl.push_back(v(1, 0, 16'h0000, 2'b00, 0, mk(8'h00, 8'h00, 2'b00, 3'b000, 0, 0, 0, 4'd0)));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].m, tbl[i].s);
      check($sformatf("vec%0d", i), 32'(get_outs()), 32'(tbl[i].e));
    end

    // Fill the FIFO with wvalid held; extra words must wait for a pop
    step(1, 0, 16'h0, 2'b00, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 16'($urandom), 2'($urandom), 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 16'h9999, 2'b01, 0);
      check("full_lvl", 32'(fifo_level), 32'd8);
      check("full_rdy", 32'(sys_wready), 32'd0);
    end
    step(0, 1, 16'h9999, 2'b01, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 16'h9999, 2'b01, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 16'h0, 2'b00, (i == 2) ? 1'b1 : 1'b0);

    // Extra wr_start pulses during a burst are ignored
    step(1, 0, 16'h0, 2'b00, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 16'($urandom), 2'b00, 0);
    step(0, 0, 16'h0, 2'b00, 1);
    beats = 0;
    pre_post = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 16'h0, 2'b00, (i == 3 || i == 5) ? 1'b1 : 1'b0);
      if (dq_oe) beats++;
      else if (dqs_oe) pre_post++;
    end
    check("beat_count", 32'(beats), 32'd4);
    check("pre_post_count", 32'(pre_post), 32'd2);

    // Reset during the second beat releases the bus with no postamble
    step(1, 0, 16'h0, 2'b00, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 16'($urandom), 2'b00, 0);
    step(0, 0, 16'h0, 2'b00, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 2'b00, 0);
    check("beat2_oe", 32'(dq_oe), 32'd1);
    step(1, 0, 16'h0, 2'b00, 0);
    check("rst_mid", 32'(get_outs()), 32'(mk(8'h00, 8'h00, 2'b00, 3'b000, 0, 0, 0, 4'd0)));
    step(0, 0, 16'h0, 2'b00, 0);
    check("no_post", 32'(get_outs()), 32'(mk(8'h00, 8'h00, 2'b00, 3'b000, 0, 0, 1, 4'd0)));

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 4) < 3) ? 1'b1 : 1'b0,
           16'($urandom), 2'($urandom),
           ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_datapath_write.md
Name: ddr_datapath_write

Overview:
- Write-direction datapath for the DDR controller, the counterpart of the read capture path.
- Buffers 16-bit system write words and data masks in a small FIFO.
- On a write-command pulse from the command FSM, serialises each word into rise/fall byte pairs for the external DDR output registers.
- Generates DQ/DQS output enables, DQS preamble/postamble and DM. High byte goes on the rising edge, low byte on the falling edge, matching the {high,low} ordering of read data.

Parameters:
- BURST_LEN, 4, 16-bit words per write burst (one word per clk); legal 2, 4, 8
- FIFO_DEPTH, 8, write FIFO entries (power of 2, >= BURST_LEN)
- WL, 2, clk cycles from wr_start sample to DQS preamble cycle; legal 1..7

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- sys_data_w  in  16  write word; [15:8] rise byte, [7:0] fall byte
- sys_mask_w  in  2  byte mask; [1] masks rise byte, [0] masks fall byte; 1 = do not write
- sys_wvalid  in  1  write word valid
- sys_wready  out  1  FIFO can accept
- wr_start  in  1  one-cycle pulse from command FSM when WRITE command issued
- dq_rise  out  8  byte for DQ on rising edge
- dq_fall  out  8  byte for DQ on falling edge
- dm_rise  out  1  DM for rise byte
- dm_fall  out  1  DM for fall byte
- dq_oe  out  1  DQ/DM output enable
- dqs_oe  out  1  DQS output enable
- dqs_rise  out  1  DQS level driven in first half-cycle
- wr_busy  out  1  burst sequence in progress (state != IDLE)
- wr_underrun  out  1  sticky: FIFO empty at a burst beat
- fifo_level  out  4  current FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset (rst=1 at a clk edge): FIFO flushed (level 0), FSM to IDLE. All outputs 0, including sys_wready, dq_*, dm_*, dqs_*, wr_underrun. This also applies mid-burst: the bus is released on the next edge and no postamble is driven.
- FIFO:
  - sys_wready = !full && !rst.
  - Push when sys_wvalid && sys_wready; word and mask are stored together.
  - Push is blocked while full even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states and timing, with edge k = the edge where wr_start is sampled in IDLE:
  - IDLE: wr_start -> LATENCY if WL>1, else -> PREAMBLE.
  - LATENCY: counts WL-1 cycles -> PREAMBLE.
  - PREAMBLE: 1 cycle; dqs_oe=1, dqs_rise=0, dq_oe=0 -> BURST. Preamble cycle is cycle k+WL.
  - BURST: BURST_LEN cycles, beats at cycles k+WL+1 .. k+WL+BURST_LEN.
    - Each beat pops one FIFO entry: dq_rise=data[15:8], dq_fall=data[7:0], dm_rise=mask[1], dm_fall=mask[0].
    - dq_oe=1, dqs_oe=1, dqs_rise=1.
    - After the last beat -> POSTAMBLE.
  - POSTAMBLE: 1 cycle; dqs_oe=1, dqs_rise=0, dq_oe=0 -> IDLE.
- All pad-side outputs are registered and change only on clk edges.
- When dq_oe=0: dq_rise/dq_fall/dm_* are 0.
- wr_start outside IDLE is ignored (no queuing); the command FSM must respect wr_busy.
- Underrun (FIFO empty at a beat): no pop; dq_* = 0, dm_rise = dm_fall = 1 (beat fully masked); wr_underrun set. The burst still completes its full BURST_LEN beats.
- wr_underrun clears only on rst or on the next accepted wr_start.
- A push in the same cycle as a pop from an empty FIFO is not visible to that beat; it is available at the next beat.

Test Plan:
- Reset, then push 4 words 0xA1B2, 0xC3D4, 0xE5F6, 0x0718 with mask 0, WL=2, pulse wr_start at edge k -> dqs_oe=1/dq_oe=0 at k+2; at k+3..k+6 dq_rise/dq_fall = A1/B2, C3/D4, E5/F6, 07/18 with dm=0 and dqs_rise=1; postamble at k+7; wr_busy low at k+8; fifo_level 0.
- Push 8 words with wvalid held high and no burst -> sys_wready drops after the 8th accept, fifo_level=8, and a 9th word is not accepted until a burst pops.
- Push only 2 words, then start a burst -> beats 3–4 show dq=0, dm_rise=dm_fall=1, wr_underrun=1; wr_underrun clears on the next wr_start.
- Word 0x55AA with mask 2'b10 -> that beat shows dm_rise=1, dm_fall=0.
- Second wr_start pulse during BURST -> ignored; exactly 4 beats and one postamble are driven.
- Assert rst during the second beat -> the next edge shows all outputs 0, fifo_level=0, state IDLE, and no postamble.
